// File: rtl/bounce_emu_pkg.sv
// Shared types and constants for the contact-bounce emulator.
package bounce_emu_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_BOUNCE = 1'b1
  } state_t;

  localparam int unsigned TOGGLE_W       = 8;
  localparam logic [15:0] DEFAULT_TAPS16 = 16'hB400;
  localparam logic [7:0]  TOGGLE_SAT     = 8'd255;

  // Saturating increment for the toggle counter.
  function automatic logic [TOGGLE_W-1:0] sat_inc(input logic [TOGGLE_W-1:0] v);
    return (v == TOGGLE_SAT) ? v : v + TOGGLE_W'(1);
  endfunction

endpackage

// File: rtl/bounce_emu_if.sv
// Level-in / bouncy-out bundle between the test controller and the emulator.
interface bounce_emu_if;
  import bounce_emu_pkg::*;

  logic                i_Enable;
  logic                i_Clean;
  logic                o_Bouncy;
  logic                o_Busy;
  logic [TOGGLE_W-1:0] o_Toggles;

  modport master (
    output i_Enable,
    output i_Clean,
    input  o_Bouncy,
    input  o_Busy,
    input  o_Toggles
  );

  modport slave (
    input  i_Enable,
    input  i_Clean,
    output o_Bouncy,
    output o_Busy,
    output o_Toggles
  );

endinterface

// File: rtl/bounce_emulator_lfsr.sv
// Free-running shift-right Galois LFSR; an all-zero seed would lock up, so it becomes 1.
module lfsr_galois import bounce_emu_pkg::*; #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS16
) (
  input  logic             i_CLK,
  input  logic             r_Reset,
  output logic [WIDTH-1:0] o_Value
);

  localparam logic [WIDTH-1:0] RESET_VALUE = (SEED == '0) ? WIDTH'(1) : SEED;

  // Shift right, folding the tap mask in whenever a one falls out of the LSB.
  always_ff @(posedge i_CLK) begin
    if (r_Reset) begin
      o_Value <= RESET_VALUE;
    end else begin
      o_Value <= (o_Value >> 1) ^ (o_Value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/bounce_emulator.sv
// Contact-bounce generator: a clean level in, a pseudo-randomly chattering copy out.
module bounce_emulator import bounce_emu_pkg::*; #(
  parameter int unsigned           BOUNCE_CYCLES = 2000,
  parameter int unsigned           LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED          = 16'hACE1,
  parameter int unsigned           GAP_LOG2      = 4,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = DEFAULT_TAPS16
) (
  input  logic        i_CLK,
  input  logic        r_Reset,
  bounce_emu_if.slave bus
);

  localparam int unsigned      WIN_W    = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int unsigned      GAP_W    = GAP_LOG2 + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BOUNCE_CYCLES - 1);

  state_t              state_q,   state_d;
  logic                target_q,  target_d;
  logic                bouncy_q,  bouncy_d;
  logic                busy_q,    busy_d;
  logic [TOGGLE_W-1:0] toggles_q, toggles_d;
  logic [WIN_W-1:0]    win_q,     win_d;
  logic [GAP_W-1:0]    gap_q,     gap_d;

  logic [LFSR_WIDTH-1:0] lfsr_value;
  logic [GAP_W-1:0]      gap_draw;
  logic                  lfsr_unused;

  lfsr_galois #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (SEED),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .i_CLK   (i_CLK),
    .r_Reset (r_Reset),
    .o_Value (lfsr_value)
  );

  // Next toggle distance, 1..2^GAP_LOG2 cycles.
  assign gap_draw    = GAP_W'(lfsr_value[GAP_LOG2-1:0]) + GAP_W'(1);
  assign lfsr_unused = ^lfsr_value[LFSR_WIDTH-1:GAP_LOG2];

  // Next-state and output decode; window end outranks retrigger, enable drop and toggles.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    bouncy_d  = bouncy_q;
    busy_d    = busy_q;
    toggles_d = toggles_q;
    win_d     = win_q;
    gap_d     = gap_q;

    case (state_q)
      ST_IDLE: begin
        busy_d   = 1'b0;
        bouncy_d = target_q;
        if (!bus.i_Enable) begin
          target_d = bus.i_Clean;
          bouncy_d = bus.i_Clean;
        end else if (bus.i_Clean != target_q) begin
          target_d  = bus.i_Clean;
          bouncy_d  = bus.i_Clean;
          win_d     = '0;
          gap_d     = gap_draw;
          toggles_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_BOUNCE;
        end
      end

      ST_BOUNCE: begin
        win_d = win_q + WIN_W'(1);
        gap_d = gap_q - GAP_W'(1);
        if (win_q == WIN_LAST) begin
          bouncy_d = target_q;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (bus.i_Enable && (bus.i_Clean != target_q)) begin
          target_d = bus.i_Clean;
          bouncy_d = bus.i_Clean;
          win_d    = '0;
          gap_d    = gap_draw;
        end else if (!bus.i_Enable) begin
          target_d = bus.i_Clean;
          bouncy_d = bus.i_Clean;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (gap_q == GAP_W'(1)) begin
          bouncy_d  = ~bouncy_q;
          gap_d     = gap_draw;
          toggles_d = sat_inc(toggles_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge i_CLK) begin
    if (r_Reset) begin
      state_q   <= ST_IDLE;
      target_q  <= 1'b0;
      bouncy_q  <= 1'b0;
      busy_q    <= 1'b0;
      toggles_q <= '0;
      win_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      bouncy_q  <= bouncy_d;
      busy_q    <= busy_d;
      toggles_q <= toggles_d;
      win_q     <= win_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.o_Bouncy  = bouncy_q;
  assign bus.o_Busy    = busy_q;
  assign bus.o_Toggles = toggles_q;

endmodule

// File: tb/tb_bounce_emulator.sv
// Self-checking bench for bounce_emulator: vector table, corner sequences, random vs. model.
module tb_bounce_emulator;

  localparam int BC     = 64;
  localparam int BC_SAT = 8192;

  logic i_CLK = 1'b0;
  logic rst_a;
  logic rst_s;

  int checks = 0;
  int errors = 0;

  always #5 i_CLK = ~i_CLK;

  bounce_emu_if bus_a ();
  bounce_emu_if bus_s ();

  bounce_emulator #(
    .BOUNCE_CYCLES (BC),
    .LFSR_WIDTH    (16),
    .SEED          (16'hACE1),
    .GAP_LOG2      (4)
  ) dut (
    .i_CLK   (i_CLK),
    .r_Reset (rst_a),
    .bus     (bus_a)
  );

  bounce_emulator #(
    .BOUNCE_CYCLES (BC_SAT),
    .LFSR_WIDTH    (16),
    .SEED          (16'hACE1),
    .GAP_LOG2      (1)
  ) dut_sat (
    .i_CLK   (i_CLK),
    .r_Reset (rst_s),
    .bus     (bus_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window end and next toggle are tracked as absolute edge numbers.
  logic [15:0] m_lfsr    = 16'hACE1;
  int          m_cyc     = 0;
  bit          m_busy    = 0;
  bit          m_target  = 0;
  bit          m_bouncy  = 0;
  int          m_toggles = 0;
  int          m_end     = 0;
  int          m_next    = 0;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_edge(input bit rst, input bit en, input bit clean);
    int g;
    if (rst) begin
      m_lfsr = 16'hACE1; m_busy = 0; m_target = 0; m_bouncy = 0; m_toggles = 0;
    end else begin
      g = int'(m_lfsr % 16) + 1;
      if (!m_busy) begin
        if (!en) begin
          m_target = clean; m_bouncy = clean;
        end else if (clean != m_target) begin
          m_target = clean; m_bouncy = clean; m_busy = 1; m_toggles = 0;
          m_end = m_cyc + BC; m_next = m_cyc + g;
        end
      end else if (m_cyc == m_end) begin
        m_bouncy = m_target; m_busy = 0;
      end else if (en && clean != m_target) begin
        m_target = clean; m_bouncy = clean;
        m_end = m_cyc + BC; m_next = m_cyc + g;
      end else if (!en) begin
        m_target = clean; m_bouncy = clean; m_busy = 0;
      end else if (m_cyc == m_next) begin
        m_bouncy = !m_bouncy;
        if (m_toggles < 255) m_toggles++;
        m_next = m_cyc + g;
      end
      m_lfsr = lfsr_adv(m_lfsr);
    end
    m_cyc++;
  endtask

  // One clock on the main DUT, checked against the model just after the edge.
  task automatic step(input bit rst, input bit en, input bit clean);
    rst_a = rst; bus_a.i_Enable = en; bus_a.i_Clean = clean;
    @(posedge i_CLK);
    model_edge(rst, en, clean);
    #1;
    chk("model_bouncy",  32'(bus_a.o_Bouncy),  32'(m_bouncy));
    chk("model_busy",    32'(bus_a.o_Busy),    32'(m_busy));
    chk("model_toggles", 32'(bus_a.o_Toggles), 32'(m_toggles));
  endtask

  task automatic single_edge(output logic [79:0] trace);
    int   last_t;
    int   tog_end;
    logic prev;
    trace = '0;
    tog_end = 0;
    step(1, 1, 0); step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(0, 1, 1);
    chk("rise_bouncy", 32'(bus_a.o_Bouncy), 1);
    chk("rise_busy",   32'(bus_a.o_Busy),   1);
    trace[0] = bus_a.o_Bouncy;
    prev   = 1'b1;
    last_t = 1;
    for (int k = 2; k <= 80; k++) begin
      step(0, 1, 1);
      trace[k-1] = bus_a.o_Bouncy;
      if (k <= BC && bus_a.o_Bouncy !== prev) begin
        chk("toggle_gap", 32'((k - last_t) >= 1 && (k - last_t) <= 16), 1);
        last_t = k;
      end
      prev = bus_a.o_Bouncy;
      if (k == BC) chk("busy_last_cycle", 32'(bus_a.o_Busy), 1);
      if (k == BC + 1) begin
        chk("settle_bouncy",   32'(bus_a.o_Bouncy), 1);
        chk("settle_busy",     32'(bus_a.o_Busy), 0);
        chk("toggles_nonzero", 32'(bus_a.o_Toggles >= 8'd1), 1);
        tog_end = m_toggles;
      end
      if (k > BC + 1) begin
        chk("toggles_stable", 32'(bus_a.o_Toggles), 32'(tog_end));
        chk("held_bouncy",    32'(bus_a.o_Bouncy), 1);
      end
    end
  endtask

  typedef struct {
    bit rst;
    bit en;
    bit clean;
    bit exp_bouncy;
    bit exp_busy;
    int exp_tog;
  } vec_t;

  vec_t        vecs [14];
  logic [79:0] tr1, tr2;
  int          tog_ref;
  bit          r_rst, r_en, r_clean;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1; rst_s = 1;
    bus_a.i_Enable = 1; bus_a.i_Clean = 0;
    bus_s.i_Enable = 1; bus_s.i_Clean = 0;

    // Reset with level high, window start on release, enable drop, then passthrough.
    for (int i = 0; i < 3; i++) vecs[i] = '{1, 1, 1, 0, 0, 0};
    vecs[3] = '{0, 1, 1, 1, 1, 0};
    for (int i = 4; i < 14; i++) vecs[i] = '{0, 0, bit'(i % 2), bit'(i % 2), 0, 0};

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].clean);
      chk("vec_bouncy",  32'(bus_a.o_Bouncy),  32'(vecs[i].exp_bouncy));
      chk("vec_busy",    32'(bus_a.o_Busy),    32'(vecs[i].exp_busy));
      chk("vec_toggles", 32'(bus_a.o_Toggles), 32'(vecs[i].exp_tog));
    end

    single_edge(tr1);

    // Passthrough after a window leaves the toggle count alone.
    tog_ref = m_toggles;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, bit'(i % 2));
      chk("pass_bouncy",  32'(bus_a.o_Bouncy), 32'(i % 2));
      chk("pass_busy",    32'(bus_a.o_Busy), 0);
      chk("pass_toggles", 32'(bus_a.o_Toggles), 32'(tog_ref));
    end

    single_edge(tr2);
    chk("determinism", 32'(tr1 === tr2), 1);

    // Mid-window reversal restarts the window.
    step(1, 1, 0); step(1, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 1; i < 20; i++) step(0, 1, 1);
    step(0, 1, 0);
    chk("retrig_bouncy", 32'(bus_a.o_Bouncy), 0);
    chk("retrig_busy",   32'(bus_a.o_Busy), 1);
    for (int s = 21; s <= 83; s++) begin
      step(0, 1, 0);
      chk("retrig_busy_hold", 32'(bus_a.o_Busy), 1);
    end
    step(0, 1, 0);
    chk("retrig_end_busy",   32'(bus_a.o_Busy), 0);
    chk("retrig_end_bouncy", 32'(bus_a.o_Bouncy), 0);

    // Reset mid-window, then release with the level still high.
    step(0, 1, 0); step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 1; i < 30; i++) step(0, 1, 1);
    step(1, 1, 1);
    chk("rstmid_bouncy",  32'(bus_a.o_Bouncy), 0);
    chk("rstmid_busy",    32'(bus_a.o_Busy), 0);
    chk("rstmid_toggles", 32'(bus_a.o_Toggles), 0);
    step(0, 1, 1);
    chk("rstmid_rewin_bouncy", 32'(bus_a.o_Bouncy), 1);
    chk("rstmid_rewin_busy",   32'(bus_a.o_Busy), 1);

    // Random traffic against the model.
    step(1, 1, 0);
    r_clean = 0;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 399) == 0);
      r_en  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 44) == 0) r_clean = !r_clean;
      step(r_rst, r_en, r_clean);
    end

    // Saturation on the long-window, short-gap instance.
    @(posedge i_CLK); #1;
    @(posedge i_CLK); #1;
    rst_s = 0; bus_s.i_Clean = 1;
    for (int k = 1; k <= BC_SAT + 20; k++) begin
      @(posedge i_CLK); #1;
      if (k == 1)          chk("sat_start_busy", 32'(bus_s.o_Busy), 1);
      if (k == 1000)       chk("sat_reached",    32'(bus_s.o_Toggles), 255);
      if (k == BC_SAT)     chk("sat_busy_last",  32'(bus_s.o_Busy), 1);
      if (k == BC_SAT + 1) begin
        chk("sat_end_busy",    32'(bus_s.o_Busy), 0);
        chk("sat_end_bouncy",  32'(bus_s.o_Bouncy), 1);
        chk("sat_end_toggles", 32'(bus_s.o_Toggles), 255);
      end
      if (k == BC_SAT + 20) chk("sat_hold", 32'(bus_s.o_Toggles), 255);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bounce_emulator.md
Name: bounce_emulator

Overview:
- Synthesizable contact-bounce generator: takes a clean level and drives a deliberately bouncy copy of it.
- On each level change it emits pseudo-random toggles for a fixed window, then settles to the new level.
- Sits between the board-test controller and the button-input conditioning path, for hardware-in-loop exercise of the debounce logic without a physical switch.

Parameters:
- BOUNCE_CYCLES, 2000: length of the bounce window in i_CLK cycles, must be ≥2.
- LFSR_WIDTH, 16: width of the free-running Galois LFSR.
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 1.
- GAP_LOG2, 4: toggle gap is drawn from 1..2^GAP_LOG2 cycles.

Ports:
- i_CLK  in  1  system clock
- r_Reset  in  1  synchronous reset, active-high
- i_Enable  in  1  1 = emulate bounce; 0 = clean passthrough
- i_Clean  in  1  ideal switch level, synchronous to i_CLK
- o_Bouncy  out  1  emulated switch output
- o_Busy  out  1  high while a bounce window is active
- o_Toggles  out  8  toggles in the last or current window, saturating at 255

Behaviour:
- Clock and reset: reset r_Reset, synchronous, active-high; clock i_CLK.
- Reset values:
  - o_Bouncy=0, o_Busy=0, o_Toggles=0.
  - State=IDLE, r_Target=0.
  - LFSR=SEED (1 if SEED==0).
  - Window and gap counters = 0.
- LFSR: advances every cycle regardless of state. gap_draw = LFSR[GAP_LOG2-1:0] + 1 (range 1..2^GAP_LOG2).
- Counter widths:
  - Window counter: $clog2(BOUNCE_CYCLES) bits.
  - Gap counter: GAP_LOG2+1 bits.
- State IDLE:
  - o_Bouncy holds r_Target; o_Busy=0.
  - Trigger: i_Clean != r_Target with i_Enable=1. On the next edge:
    - r_Target <= i_Clean and o_Bouncy <= i_Clean (first edge appears with 1-cycle latency).
    - window <= 0, gap <= gap_draw, o_Toggles <= 0, o_Busy <= 1.
    - State -> BOUNCE.
  - With i_Enable=0: r_Target <= i_Clean and o_Bouncy <= i_Clean every cycle (1-cycle registered passthrough); o_Busy stays 0.
- State BOUNCE, each cycle:
  - window <= window + 1 and gap <= gap - 1.
  - When gap==1: o_Bouncy <= ~o_Bouncy, gap <= gap_draw, o_Toggles <= sat(o_Toggles + 1).
  - When window == BOUNCE_CYCLES-1: o_Bouncy <= r_Target, o_Busy <= 0, state -> IDLE.
- Priority and boundary rules, in priority order:
  - r_Reset beats everything, including mid-window. Output goes to 0 next cycle even if i_Clean=1; a subsequent i_Clean=1 then retriggers a window.
  - Window end beats a coincident toggle. The final value is always r_Target; o_Toggles is not incremented that cycle.
  - Retrigger: i_Clean != r_Target during BOUNCE, i.e. the clean level reverses mid-window. r_Target <= i_Clean, window <= 0, gap <= gap_draw, o_Bouncy <= i_Clean; o_Toggles continues counting.
  - i_Enable falling during BOUNCE: next cycle o_Bouncy <= i_Clean, r_Target <= i_Clean, o_Busy <= 0, state -> IDLE.
  - o_Toggles saturates at 255; no wrap.
- Settling guarantee: o_Bouncy equals i_Clean no later than BOUNCE_CYCLES+1 cycles after the last i_Clean change.
- Determinism: identical reset and stimulus give an identical o_Bouncy waveform.

Decomposition:
- Shared package bounce_emu_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_BOUNCE=1'b1.
  - Default Galois tap mask for 16 bits: 16'hB400.
  - Toggle-count saturation constant 8'd255.
- One sub-module: lfsr_galois
  - Parameters: WIDTH, SEED, TAPS.
  - Ports: i_CLK, r_Reset, o_Value.
  - Free-running; shift-right Galois form; zero seed mapped to 1.
- FSM, counters and output register live in bounce_emulator.

Test Plan (all scenarios use BOUNCE_CYCLES=64, GAP_LOG2=4, SEED=16'hACE1):
- Reset check: assert r_Reset for 3 cycles with i_Clean=1, i_Enable=1 -> o_Bouncy=0, o_Busy=0, o_Toggles=0 during reset. Then a window starts the cycle after release.
- Single rising edge: i_Clean 0->1 at cycle T ->
  - o_Bouncy=1 and o_Busy=1 at T+1.
  - Every gap between o_Bouncy transitions within the window lies in 1..16.
  - o_Bouncy=1 and o_Busy=0 from T+65 onward.
  - o_Toggles ≥1 and stable after T+65.
- Mid-window retrigger: rise at T, fall at T+20 -> o_Bouncy=0 at T+21; o_Busy stays high until T+85; final o_Bouncy=0.
- Passthrough: i_Enable=0, toggle i_Clean every cycle for 10 cycles -> o_Bouncy equals i_Clean delayed by 1 cycle; o_Busy=0; o_Toggles unchanged.
- Reset mid-window: rise at T, r_Reset at T+30 -> o_Bouncy=0 and o_Busy=0 at T+31. Deassert with i_Clean still 1 -> new window begins one cycle later.
- Determinism and saturation:
  - Run the single-edge scenario twice from reset -> bit-identical o_Bouncy traces.
  - With BOUNCE_CYCLES=8192 and GAP_LOG2=1 -> o_Toggles reaches and holds 255.
